// File: rtl/rvseed_regfile.sv
// rvseed_regfile: RVSEED integer register file with byte-offset addressing,
// x0 hardwired to zero, combinational read ports with write-to-read bypass,
// a per-register busy scoreboard and a sticky address-error flag.
// There are no handshakes: every input is sampled on every rising edge and
// every read port is evaluated every cycle (no valid/ready pairs exist).
module rvseed_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_RPORTS = 2,
   parameter int CNT_WIDTH  = $clog2(NUM_REGS + 1)
) (
   input  logic                             clk_reg,
   input  logic                             rst_reg_n,
   input  logic                             reg_wen,
   input  logic [ADDR_WIDTH-1:0]            reg_waddr,
   input  logic [DATA_WIDTH-1:0]            reg_wdata,
   input  logic                             rsv_en,
   input  logic [ADDR_WIDTH-1:0]            rsv_addr,
   input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] rd_raddr,
   output logic [NUM_RPORTS*DATA_WIDTH-1:0] rd_rdata,
   output logic [NUM_RPORTS-1:0]            rd_busy,
   output logic [NUM_REGS-1:0]              busy_vec,
   output logic [CNT_WIDTH-1:0]             busy_cnt,
   output logic                             err_addr,
   input  logic                             err_clr
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-3:0] NUM_REGS_A = (ADDR_WIDTH-2)'(NUM_REGS);

   // A byte address is usable only when word aligned and inside the file.
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return (a[1:0] == 2'b00) && (a[ADDR_WIDTH-1:2] < NUM_REGS_A);
   endfunction

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_q, busy_d;
   logic [NUM_REGS-1:0]   w_dec, r_dec;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  err_q, err_set;

   logic                  w_ok, r_ok, w_hit, r_hit;
   logic [IDX_W-1:0]      w_idx, r_idx;
   logic [NUM_RPORTS-1:0] rd_bad;

   // Writeback and reservation decode; x0 targets are dropped here.
   assign w_ok  = addr_ok(reg_waddr);
   assign w_idx = reg_waddr[IDX_W+1:2];
   assign w_hit = reg_wen && w_ok && (w_idx != '0);

   assign r_ok  = addr_ok(rsv_addr);
   assign r_idx = rsv_addr[IDX_W+1:2];
   assign r_hit = rsv_en && r_ok && (r_idx != '0);

   // Read ports: x0/invalid read zero, a same-cycle writeback is forwarded,
   // and a forwarded operand is no longer reported as pending.
   for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] a;
      logic                  ok;
      logic [IDX_W-1:0]      idx;
      logic                  live;
      logic                  bypass;

      assign a      = rd_raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign ok     = addr_ok(a);
      assign idx    = a[IDX_W+1:2];
      assign live   = rst_reg_n && ok && (idx != '0);
      assign bypass = w_hit && (w_idx == idx);
      assign rd_bad[p] = ~ok;
      assign rd_rdata[p*DATA_WIDTH +: DATA_WIDTH] =
         !live  ? '0 :
         bypass ? reg_wdata : regs[idx];
      assign rd_busy[p] = live && busy_q[idx] && !bypass;
   end

   // Next scoreboard state: writeback clears, reservation sets and wins.
   always_comb begin
      w_dec = '0;
      r_dec = '0;
      if (w_hit) w_dec[w_idx] = 1'b1;
      if (r_hit) r_dec[r_idx] = 1'b1;
      busy_d    = (busy_q & ~w_dec) | r_dec;
      busy_d[0] = 1'b0;
   end

   // Population count of the next scoreboard so busy_cnt tracks busy_vec.
   always_comb begin
      cnt_d = '0;
      for (int n = 0; n < NUM_REGS; n++) begin
         cnt_d = cnt_d + CNT_WIDTH'(busy_d[n]);
      end
   end

   assign err_set = (reg_wen && !w_ok) || (rsv_en && !r_ok) || (|rd_bad);

   // Register storage; x0 is never written so it stays zero.
   always_ff @(posedge clk_reg or negedge rst_reg_n) begin
      if (!rst_reg_n) begin
         for (int n = 0; n < NUM_REGS; n++) begin
            regs[n] <= '0;
         end
      end else if (w_hit) begin
         regs[w_idx] <= reg_wdata;
      end
   end

   // Scoreboard and its count; reset discards all pending reservations.
   always_ff @(posedge clk_reg or negedge rst_reg_n) begin
      if (!rst_reg_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // Sticky address error; a new error beats a simultaneous clear.
   always_ff @(posedge clk_reg or negedge rst_reg_n) begin
      if (!rst_reg_n) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end else if (err_clr) begin
         err_q <= 1'b0;
      end
   end

   assign busy_vec = busy_q;
   assign busy_cnt = cnt_q;
   assign err_addr = err_q;

endmodule

// File: tb/tb_rvseed_regfile.sv
// Directed bench for rvseed_regfile with default parameters
// (32 x 32-bit registers, 16-bit byte addresses, 2 read ports).
module tb_rvseed_regfile;

   logic        clk_reg;
   logic        rst_reg_n;
   logic        reg_wen;
   logic [15:0] reg_waddr;
   logic [31:0] reg_wdata;
   logic        rsv_en;
   logic [15:0] rsv_addr;
   logic [31:0] rd_raddr;
   logic [63:0] rd_rdata;
   logic [1:0]  rd_busy;
   logic [31:0] busy_vec;
   logic [5:0]  busy_cnt;
   logic        err_addr;
   logic        err_clr;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   rvseed_regfile dut (
      .clk_reg   (clk_reg),
      .rst_reg_n (rst_reg_n),
      .reg_wen   (reg_wen),
      .reg_waddr (reg_waddr),
      .reg_wdata (reg_wdata),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .rd_raddr  (rd_raddr),
      .rd_rdata  (rd_rdata),
      .rd_busy   (rd_busy),
      .busy_vec  (busy_vec),
      .busy_cnt  (busy_cnt),
      .err_addr  (err_addr),
      .err_clr   (err_clr)
   );

   // Clock: 10 time-unit period.
   initial clk_reg = 1'b0;
   always #5 clk_reg = ~clk_reg;

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk_reg);
      #1;
   endtask

   task automatic idle();
      reg_wen   = 1'b0;
      reg_waddr = 16'h0;
      reg_wdata = 32'h0;
      rsv_en    = 1'b0;
      rsv_addr  = 16'h0;
      err_clr   = 1'b0;
   endtask

   task automatic set_rd(input logic [15:0] a0, input logic [15:0] a1);
      rd_raddr = {a1, a0};
   endtask

   task automatic test_reset();
      rst_reg_n = 1'b0;
      idle();
      set_rd(16'h04, 16'h08);
      reg_wen = 1'b1; reg_waddr = 16'h04; reg_wdata = 32'hFFFF_0000;
      #2;
      vec_cnt++;
      if (rd_rdata !== 64'h0) begin
         miss_cnt++; $display("FAIL reset_rdata: got %h want %h", rd_rdata, 64'h0);
      end
      vec_cnt++;
      if (rd_busy !== 2'b00 || busy_vec !== 32'h0 || busy_cnt !== 6'd0 || err_addr !== 1'b0) begin
         miss_cnt++;
         $display("FAIL reset_state: got busy=%b vec=%h cnt=%0d err=%b want 0", rd_busy, busy_vec, busy_cnt, err_addr);
      end
      tick(); tick();
      idle();
      rst_reg_n = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      set_rd(16'h08, 16'h08);
      reg_wen = 1'b1; reg_waddr = 16'h04; reg_wdata = 32'hDEAD_BEEF;
      tick();
      idle();
      set_rd(16'h04, 16'h08);
      #1;
      vec_cnt++;
      if (rd_rdata[31:0] !== 32'hDEAD_BEEF) begin
         miss_cnt++; $display("FAIL wr_rd_p0: got %h want %h", rd_rdata[31:0], 32'hDEAD_BEEF);
      end
      vec_cnt++;
      if (rd_rdata[63:32] !== 32'h0) begin
         miss_cnt++; $display("FAIL wr_rd_p1: got %h want %h", rd_rdata[63:32], 32'h0);
      end
   endtask

   task automatic test_x0();
      reg_wen = 1'b1; reg_waddr = 16'h00; reg_wdata = 32'h1234_5678;
      set_rd(16'h00, 16'h00);
      #1;
      vec_cnt++;
      if (rd_rdata !== 64'h0) begin
         miss_cnt++; $display("FAIL x0_bypass: got %h want %h", rd_rdata, 64'h0);
      end
      tick();
      idle();
      rsv_en = 1'b1; rsv_addr = 16'h00;
      #1;
      vec_cnt++;
      if (rd_rdata !== 64'h0 || err_addr !== 1'b0) begin
         miss_cnt++; $display("FAIL x0_read: got %h err=%b want 0 err=0", rd_rdata, err_addr);
      end
      tick();
      idle();
      vec_cnt++;
      if (busy_vec !== 32'h0 || busy_cnt !== 6'd0) begin
         miss_cnt++; $display("FAIL x0_rsv: got vec=%h cnt=%0d want 0", busy_vec, busy_cnt);
      end
   endtask

   task automatic test_bypass();
      set_rd(16'h28, 16'h28);
      reg_wen = 1'b1; reg_waddr = 16'h28; reg_wdata = 32'hA5A5_A5A5;
      #1;
      vec_cnt++;
      if (rd_rdata !== 64'hA5A5_A5A5_A5A5_A5A5) begin
         miss_cnt++; $display("FAIL bypass_same: got %h want %h", rd_rdata, 64'hA5A5_A5A5_A5A5_A5A5);
      end
      tick();
      // Write a neighbour; port0 must see stored x10, port1 the bypassed x11.
      reg_waddr = 16'h2C; reg_wdata = 32'h1111_1111;
      set_rd(16'h28, 16'h2C);
      #1;
      vec_cnt++;
      if (rd_rdata !== 64'h1111_1111_A5A5_A5A5) begin
         miss_cnt++; $display("FAIL bypass_other: got %h want %h", rd_rdata, 64'h1111_1111_A5A5_A5A5);
      end
      tick();
      idle();
      #1;
      vec_cnt++;
      if (rd_rdata !== 64'h1111_1111_A5A5_A5A5) begin
         miss_cnt++; $display("FAIL bypass_stored: got %h want %h", rd_rdata, 64'h1111_1111_A5A5_A5A5);
      end
   endtask

   task automatic test_scoreboard();
      rsv_en = 1'b1; rsv_addr = 16'h14;
      tick();
      idle();
      set_rd(16'h14, 16'h10);
      #1;
      vec_cnt++;
      if (busy_vec !== 32'h0000_0020 || busy_cnt !== 6'd1 || rd_busy !== 2'b01) begin
         miss_cnt++;
         $display("FAIL sb_rsv: got vec=%h cnt=%0d rd_busy=%b want 00000020 1 01", busy_vec, busy_cnt, rd_busy);
      end
      // Writeback clears the pending flag combinationally and forwards data.
      reg_wen = 1'b1; reg_waddr = 16'h14; reg_wdata = 32'h0000_0055;
      // A same-cycle reservation of x6 must not show as busy on port1 yet.
      rsv_en = 1'b1; rsv_addr = 16'h18;
      set_rd(16'h14, 16'h18);
      #1;
      vec_cnt++;
      if (rd_busy !== 2'b00 || rd_rdata[31:0] !== 32'h55) begin
         miss_cnt++; $display("FAIL sb_wb_same: got rd_busy=%b d=%h want 00 00000055", rd_busy, rd_rdata[31:0]);
      end
      tick();
      idle();
      #1;
      vec_cnt++;
      if (busy_vec !== 32'h0000_0040 || busy_cnt !== 6'd1 || rd_busy !== 2'b10) begin
         miss_cnt++;
         $display("FAIL sb_wb_next: got vec=%h cnt=%0d rd_busy=%b want 00000040 1 10", busy_vec, busy_cnt, rd_busy);
      end
   endtask

   task automatic test_back_to_back();
      rsv_en = 1'b1; rsv_addr = 16'h14;
      tick();
      // Reserve and writeback to x5 together while x5 is busy.
      reg_wen = 1'b1; reg_waddr = 16'h14; reg_wdata = 32'hCAFE_F00D;
      tick();
      // Writeback to a non-busy register (x7) leaves the scoreboard alone.
      idle();
      reg_wen = 1'b1; reg_waddr = 16'h1C; reg_wdata = 32'h7777_7777;
      tick();
      idle();
      set_rd(16'h14, 16'h1C);
      #1;
      vec_cnt++;
      if (busy_vec !== 32'h0000_0060 || busy_cnt !== 6'd2) begin
         miss_cnt++; $display("FAIL b2b_busy: got vec=%h cnt=%0d want 00000060 2", busy_vec, busy_cnt);
      end
      vec_cnt++;
      if (rd_rdata !== 64'h7777_7777_CAFE_F00D || rd_busy !== 2'b01) begin
         miss_cnt++;
         $display("FAIL b2b_data: got %h rd_busy=%b want 77777777cafef00d 01", rd_rdata, rd_busy);
      end
      reg_wen = 1'b1; reg_waddr = 16'h14; reg_wdata = 32'hCAFE_F00D;
      tick();
      reg_waddr = 16'h18; reg_wdata = 32'h6666_6666;
      tick();
      idle();
      vec_cnt++;
      if (busy_vec !== 32'h0 || busy_cnt !== 6'd0) begin
         miss_cnt++; $display("FAIL b2b_drain: got vec=%h cnt=%0d want 0 0", busy_vec, busy_cnt);
      end
   endtask

   task automatic test_err();
      set_rd(16'h04, 16'h08);
      reg_wen = 1'b1; reg_waddr = 16'h06; reg_wdata = 32'hFFFF_FFFF;
      tick();
      reg_waddr = 16'h80; reg_wdata = 32'hEEEE_EEEE;
      #1;
      vec_cnt++;
      if (err_addr !== 1'b1) begin
         miss_cnt++; $display("FAIL err_misalign: got %b want 1", err_addr);
      end
      tick();
      idle();
      set_rd(16'h04, 16'h00);
      #1;
      vec_cnt++;
      if (err_addr !== 1'b1 || rd_rdata !== 64'h0000_0000_DEAD_BEEF) begin
         miss_cnt++; $display("FAIL err_range: got err=%b d=%h want 1 00000000deadbeef", err_addr, rd_rdata);
      end
      // Invalid read addresses return zero and flag an error.
      set_rd(16'h06, 16'h80);
      rsv_en = 1'b1; rsv_addr = 16'h82;
      err_clr = 1'b1;
      #1;
      vec_cnt++;
      if (rd_rdata !== 64'h0 || rd_busy !== 2'b00) begin
         miss_cnt++; $display("FAIL err_rd_zero: got %h busy=%b want 0 00", rd_rdata, rd_busy);
      end
      tick();
      idle();
      set_rd(16'h04, 16'h08);
      #1;
      vec_cnt++;
      if (err_addr !== 1'b1 || busy_vec !== 32'h0) begin
         miss_cnt++; $display("FAIL err_set_wins: got err=%b vec=%h want 1 0", err_addr, busy_vec);
      end
      err_clr = 1'b1;
      tick();
      idle();
      vec_cnt++;
      if (err_addr !== 1'b0) begin
         miss_cnt++; $display("FAIL err_clr: got %b want 0", err_addr);
      end
      // Hold without clear after an error on read port 1 only.
      set_rd(16'h04, 16'h81);
      tick();
      set_rd(16'h04, 16'h08);
      tick();
      vec_cnt++;
      if (err_addr !== 1'b1) begin
         miss_cnt++; $display("FAIL err_hold: got %b want 1", err_addr);
      end
   endtask

   task automatic test_reset_mid();
      rsv_en = 1'b1; rsv_addr = 16'h40;
      tick();
      idle();
      reg_wen = 1'b1; reg_waddr = 16'h20; reg_wdata = 32'h0BAD_F00D;
      tick();
      idle();
      set_rd(16'h20, 16'h40);
      #1;
      vec_cnt++;
      if (rd_rdata[31:0] !== 32'h0BAD_F00D || busy_vec !== 32'h0001_0000 || busy_cnt !== 6'd1) begin
         miss_cnt++;
         $display("FAIL mid_pre: got d=%h vec=%h cnt=%0d want 0badf00d 00010000 1", rd_rdata[31:0], busy_vec, busy_cnt);
      end
      #1;
      rst_reg_n = 1'b0;
      #1;
      vec_cnt++;
      if (rd_rdata !== 64'h0 || rd_busy !== 2'b00 || busy_vec !== 32'h0 || busy_cnt !== 6'd0 || err_addr !== 1'b0) begin
         miss_cnt++;
         $display("FAIL mid_reset: got d=%h rb=%b vec=%h cnt=%0d err=%b want all 0", rd_rdata, rd_busy, busy_vec, busy_cnt, err_addr);
      end
      tick();
      rst_reg_n = 1'b1;
      tick();
      set_rd(16'h04, 16'h20);
      #1;
      vec_cnt++;
      if (rd_rdata !== 64'h0 || busy_vec !== 32'h0) begin
         miss_cnt++; $display("FAIL mid_after: got d=%h vec=%h want 0 0", rd_rdata, busy_vec);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_x0();
      test_bypass();
      test_scoreboard();
      test_back_to_back();
      test_err();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/rvseed_regfile.md
# rvseed_regfile

Parametrised successor to the RVSEED integer register file. It holds NUM_REGS general-purpose registers of DATA_WIDTH bits, addressed by byte offset (register n at offset 4·n), with register x0 hardwired to zero. It provides NUM_RPORTS combinational read ports with write-to-read bypass, a per-register busy scoreboard for in-flight producers, and a sticky address-error flag. It sits between decode/issue (reads and reservations) and writeback (writes) in the RVSEED core.

## Interface
- DATA_WIDTH, 32, register width
- NUM_REGS, 32, register count; power of two, 2..64
- ADDR_WIDTH, 16, byte-offset address width
- NUM_RPORTS, 2, number of read ports, 1..4
- CNT_WIDTH, $clog2(NUM_REGS+1), width of busy_cnt
- clk_reg  input  1  clock, rising edge
- rst_reg_n  input  1  reset; asynchronous, active-low
- reg_wen  input  1  writeback enable
- reg_waddr  input  ADDR_WIDTH  writeback byte address
- reg_wdata  input  DATA_WIDTH  writeback data
- rsv_en  input  1  reserve destination (mark busy)
- rsv_addr  input  ADDR_WIDTH  reserve byte address
- rd_raddr  input  NUM_RPORTS·ADDR_WIDTH  packed read addresses; port p at [p·ADDR_WIDTH +: ADDR_WIDTH]
- rd_rdata  output  NUM_RPORTS·DATA_WIDTH  packed read data
- rd_busy  output  NUM_RPORTS  read operand still pending
- busy_vec  output  NUM_REGS  scoreboard state, bit n = xn
- busy_cnt  output  CNT_WIDTH  population count of busy_vec
- err_addr  output  1  sticky: invalid address seen
- err_clr  input  1  clear err_addr

## Operation
- Address valid: addr[1:0]==0 and addr[ADDR_WIDTH-1:2] < NUM_REGS. Index = addr >> 2.
- Write: reg_wen & valid & index≠0 → reg[index] ← reg_wdata at the next edge. Writes to x0 are silently dropped with no error.
- Read port p: index 0 or invalid → 0. Otherwise, a bypass hit (reg_wen & valid waddr & same nonzero index) → reg_wdata. Otherwise → reg[index].
- Scoreboard: busy[0] is constant 0. For n≠0, next busy[n] is:
  - 1 if rsv_en hits n; reservation wins when it coincides with writeback to the same n.
  - 0 if writeback hits n and there is no reservation to n.
  - otherwise unchanged.
- Writeback to a non-busy register is legal and leaves it 0. Reserving an already-busy register is legal and leaves it 1.
- rd_busy[p] = busy[idx_p] & ~(writeback hits idx_p this cycle). It is 0 for x0 and for invalid addresses. A same-cycle reservation does not affect it.
- busy_cnt is a registered count, consistent with busy_vec every cycle.
- err_addr next value:
  - 1 if any of (reg_wen, rsv_en) carries an invalid address, or any read port's address is invalid. Reads are always evaluated; there is no read enable.
  - else 0 if err_clr.
  - else hold.
  - Set wins over a simultaneous err_clr.
- An invalid write or reserve has no effect on storage or the scoreboard.

## Timing
- Reset (async assert, sync release at the next edge): all registers are 0, busy_vec=0, busy_cnt=0, err_addr=0. rd_rdata reads 0 for all addresses and rd_busy=0 while in reset. Reset mid-operation discards all pending reservations.
- Read latency is 0 cycles (combinational). Write is visible through storage from the cycle after the edge, and through bypass in the same cycle.
- busy_vec, busy_cnt and err_addr change only on rising edges, one cycle after the causing event.
- No handshakes; every input is sampled every cycle.

## Test plan
- Reset, then write 0xDEADBEEF to 0x04 → next cycle port0 reading 0x04 returns 0xDEADBEEF. Port1 reading 0x08 returns 0.
- Write 0x12345678 to 0x00, then read 0x00 → 0, err_addr stays 0. Reserve 0x00 → busy_vec stays 0.
- Port0 reads 0x28 while writing 0xA5A5A5A5 to 0x28 in the same cycle → rd_rdata port0 = 0xA5A5A5A5 that cycle. Stored value is visible the next cycle with the write removed.
- Reserve 0x14 → next cycle busy_vec[5]=1, busy_cnt=1, rd_busy=1 on a port reading 0x14. Writeback to 0x14 → rd_busy=0 the same cycle, busy_vec[5]=0 the next cycle.
- Same cycle: reserve 0x14 and writeback to 0x14 with busy[5]=1 → busy[5] remains 1, and stored data updates.
- Write to 0x06 (misaligned), then to 0x80 (out of range, NUM_REGS=32) → err_addr=1 next cycle, no register changes. err_clr together with a new invalid access → err_addr stays 1. err_clr alone → 0. Assert rst_reg_n=0 mid-sequence → all outputs return to 0 immediately.
